// File: rtl/miter_ctrl_pkg.sv
// miter_ctrl_pkg: shared types and default constants for the miter
// controller.
//   state_e          - controller state encoding
//   *_DEF            - default parameter values for miter_ctrl
//   state_is_busy()  - true while a test sequence is in flight
package miter_ctrl_pkg;

   localparam int RUN_CYCLES_DEF  = 12;
   localparam int HOLD_CYCLES_DEF = 3;
   localparam int CNT_W_DEF       = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_RUN1,
      S_HOLD,
      S_RUN2,
      S_DONE
   } state_e;

   function automatic logic state_is_busy(state_e s);
      return (s == S_RST) || (s == S_RUN1) || (s == S_HOLD) || (s == S_RUN2);
   endfunction

endpackage

// File: rtl/miter_ctrl_phase_timer.sv
// phase_timer: per-phase cycle counter for the miter controller.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   load         - force count to 0 (first cycle of a new phase)
//   en           - advance count by one
//   limit        - phase length in cycles (1..2^CNT_W-1)
//   count        - current position inside the phase
//   expire       - high on the last cycle of the phase (count == limit-1)
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = '0;
      else if (en)
         count_d = count_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count  = count_q;
   // limit >= 1, so count never passes limit-1 while a phase is active
   assign expire = (count_q == (limit - ONE));

endmodule

// File: rtl/miter_ctrl.sv
// miter_ctrl: sequences one equivalence test of a miter: a one-cycle reset
// pulse, a RUN1 phase, an optional enable-low HOLD phase, a RUN2 phase,
// then a one-cycle DONE with the pass/fail verdict. The first mismatch
// seen in a run/hold phase aborts straight to DONE.
// Optional feature: define MITER_CTRL_HOLD_EN to include the HOLD phase;
// without it RUN1 flows directly into RUN2 and HOLD_CYCLES is unused.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - launch request, only honoured in IDLE
//   m_out        - mismatch flag from the miter
//   dut_enable   - miter enable (RUN1/RUN2)
//   dut_reset    - miter reset (RST state, or while reset is high)
//   busy         - sequence in progress (RST..RUN2)
//   done         - one-cycle end-of-sequence pulse
//   pass         - verdict of last sequence, held until next start
//   fail_cycle   - cycle_cnt at the first mismatch
//   cycle_cnt    - saturating cycles since leaving RST
module miter_ctrl
   import miter_ctrl_pkg::*;
#(
   parameter int RUN_CYCLES  = RUN_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             m_out,
   output logic             dut_enable,
   output logic             dut_reset,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] fail_cycle,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] fail_cycle_q, fail_cycle_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

   logic             ph_load, ph_en, ph_expire;
   logic [CNT_W-1:0] ph_limit, ph_count;

   phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (ph_load),
      .en     (ph_en),
      .limit  (ph_limit),
      .count  (ph_count),
      .expire (ph_expire)
   );

   always_comb begin
      state_d      = state_q;
      pass_d       = pass_q;
      fail_cycle_d = fail_cycle_q;
      cycle_cnt_d  = cycle_cnt_q;
      ph_en        = 1'b0;
      ph_limit     = RUN_LIM;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RST;
               pass_d       = 1'b0;
               fail_cycle_d = '0;
               cycle_cnt_d  = '0;
            end
         end
         S_RST: begin
            state_d     = S_RUN1;
            cycle_cnt_d = '0;
         end
         S_RUN1, S_HOLD, S_RUN2: begin
            ph_en = 1'b1;
            if (state_q == S_HOLD)
               ph_limit = HOLD_LIM;
            if (cycle_cnt_q != '1)
               cycle_cnt_d = cycle_cnt_q + ONE;
            // a mismatch wins over a phase boundary in the same cycle
            if (m_out) begin
               state_d      = S_DONE;
               fail_cycle_d = cycle_cnt_q;
               pass_d       = 1'b0;
            end else if (ph_expire) begin
               if (state_q == S_RUN1) begin
`ifdef MITER_CTRL_HOLD_EN
                  state_d = S_HOLD;
`else
                  state_d = S_RUN2;
`endif
               end else if (state_q == S_HOLD) begin
                  state_d = S_RUN2;
               end else begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // every state change starts a new phase at count 0
   assign ph_load = (state_d != state_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pass_q       <= 1'b0;
         fail_cycle_q <= '0;
         cycle_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pass_q       <= pass_d;
         fail_cycle_q <= fail_cycle_d;
         cycle_cnt_q  <= cycle_cnt_d;
      end
   end

   assign dut_enable = (state_q == S_RUN1) || (state_q == S_RUN2);
   // reset input is passed through so the miter is held in reset with us
   assign dut_reset  = reset || (state_q == S_RST);
   assign busy       = state_is_busy(state_q);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign fail_cycle = fail_cycle_q;
   assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_miter_ctrl.sv
// tb_miter_ctrl: directed bench for miter_ctrl. A default instance
// (CNT_W=8) and a narrow instance (CNT_W=4) share all inputs; the narrow
// one shows counter saturation. Expected timing follows MITER_CTRL_HOLD_EN.
module tb_miter_ctrl;

`ifdef MITER_CTRL_HOLD_EN
   localparam bit HOLD_ON = 1'b1;
`else
   localparam bit HOLD_ON = 1'b0;
`endif
   // cycle index of the DONE pulse for a clean run started at cycle 0
   localparam int DONE_C = HOLD_ON ? 29 : 26;

   logic       clk = 1'b0;
   logic       reset, start, m_out;
   logic       en8, rst8, busy8, done8, pass8;
   logic [7:0] fail8, cnt8;
   logic       en4, rst4, busy4, done4, pass4;
   logic [3:0] fail4, cnt4;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   miter_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .m_out(m_out),
      .dut_enable(en8), .dut_reset(rst8), .busy(busy8), .done(done8),
      .pass(pass8), .fail_cycle(fail8), .cycle_cnt(cnt8)
   );

   miter_ctrl #(.CNT_W(4), .RUN_CYCLES(12), .HOLD_CYCLES(3)) dut4 (
      .clk(clk), .reset(reset), .start(start), .m_out(m_out),
      .dut_enable(en4), .dut_reset(rst4), .busy(busy4), .done(done4),
      .pass(pass4), .fail_cycle(fail4), .cycle_cnt(cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // next cycle: inputs change and outputs are sampled on the falling edge
   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic bit exp_en(input int c);
      if (HOLD_ON)
         return ((c >= 2) && (c <= 13)) || ((c >= 17) && (c <= 28));
      else
         return (c >= 2) && (c <= 25);
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      m_out = 1'b0;

      // reset values
      cyc(); cyc();
      chk("rst_dut_reset", rst8, 1);
      chk("rst_enable", en8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_pass", pass8, 0);
      chk("rst_fail_cycle", fail8, 0);
      chk("rst_cycle_cnt", cnt8, 0);
      reset = 1'b0;
      cyc();
      chk("idle_dut_reset", rst8, 0);
      chk("idle_busy", busy8, 0);

      // clean run, start held high throughout
      start = 1'b1;
      for (int c = 1; c <= DONE_C; c++) begin
         cyc();
         chk($sformatf("run_en_c%0d", c), en8, exp_en(c));
         chk($sformatf("run_busy_c%0d", c), busy8, (c < DONE_C));
         chk($sformatf("run_done_c%0d", c), done8, (c == DONE_C));
         chk($sformatf("run_dreset_c%0d", c), rst8, (c == 1));
      end
      chk("run_pass", pass8, 1);
      chk("run_fail_cycle", fail8, 0);
      chk("run_cycle_cnt", cnt8, DONE_C - 2);
      chk("run_cnt4_sat", cnt4, 15);
      chk("run_pass4", pass4, 1);
      // start in DONE is ignored: one IDLE cycle before relaunch
      cyc();
      chk("gap_busy", busy8, 0);
      chk("gap_done", done8, 0);
      chk("gap_dreset", rst8, 0);
      chk("gap_pass_held", pass8, 1);
      cyc();
      chk("relaunch_dreset", rst8, 1);
      chk("relaunch_pass_clr", pass8, 0);
      chk("relaunch_busy", busy8, 1);
      start = 1'b0;

      // abort on 5th RUN1 cycle (cycle 6)
      for (int c = 2; c <= 6; c++) cyc();
      chk("ab1_cnt", cnt8, 4);
      chk("ab1_en", en8, 1);
      m_out = 1'b1;
      cyc();
      chk("ab1_done", done8, 1);
      chk("ab1_fail_cycle", fail8, 4);
      chk("ab1_pass", pass8, 0);
      chk("ab1_en_off", en8, 0);
      chk("ab1_busy", busy8, 0);
      cyc();
      chk("ab1_idle_done", done8, 0);
      chk("ab1_idle_fail_held", fail8, 4);

      // m_out high in IDLE and RST is ignored
      start = 1'b1;
      cyc();
      chk("ign_rst_dreset", rst8, 1);
      chk("ign_fail_clr", fail8, 0);
      start = 1'b0;
      cyc();
      chk("ign_run_en", en8, 1);
      chk("ign_run_busy", busy8, 1);
      m_out = 1'b0;

      // abort late in the sequence (cycle 20)
      for (int c = 3; c <= 20; c++) cyc();
      chk("ab2_cnt", cnt8, 18);
      chk("ab2_cnt4", cnt4, 15);
      m_out = 1'b1;
      cyc();
      chk("ab2_done", done8, 1);
      chk("ab2_fail_cycle", fail8, 18);
      chk("ab2_fail4", fail4, 15);
      chk("ab2_pass", pass8, 0);
      m_out = 1'b0;
      cyc();

      // reset mid-sequence (cycle 15: HOLD when enabled)
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 2; c <= 15; c++) cyc();
      chk("mid_en_c15", en8, !HOLD_ON);
      chk("mid_busy_c15", busy8, 1);
      reset = 1'b1;
      cyc();
      chk("mid_busy", busy8, 0);
      chk("mid_done", done8, 0);
      chk("mid_en", en8, 0);
      chk("mid_dreset", rst8, 1);
      chk("mid_pass", pass8, 0);
      chk("mid_fail", fail8, 0);
      chk("mid_cnt", cnt8, 0);
      chk("mid_cnt4", cnt4, 0);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("post_done_%0d", k), done8, 0);
         chk($sformatf("post_busy_%0d", k), busy8, 0);
         chk($sformatf("post_dreset_%0d", k), rst8, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
